operand_stage: RTL

- ID/EX operand stage between decode/register_file and the execute unit.
- Consumes the register file's two read-data outputs and applies x0 zeroing and EX/MEM/WB forwarding.
- Detects load-use hazards and inserts bubbles.
- Registers the resolved operands with valid/ready flow control, plus a saturating stall-cycle counter for performance monitoring.

---
 rtl/operand_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/operand_stage.sv
// ID/EX operand stage: resolves source operands (x0 zeroing, EX/MEM/WB bypass),
// inserts one bubble per load-use pair, and registers the result with valid/ready handshaking.
module operand_stage #(
  parameter bit FORWARD_WB = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [31:0]      i_pc,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic             i_rs1_used,
  input  logic             i_rs2_used,
  input  logic [4:0]       i_rd,
  input  logic             i_rd_we,
  input  logic             i_is_load,
  input  logic [31:0]      i_rf_rs1_data,
  input  logic [31:0]      i_rf_rs2_data,
  input  logic [4:0]       i_ex_rd,
  input  logic [4:0]       i_mem_rd,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_ex_we,
  input  logic             i_mem_we,
  input  logic             i_wb_we,
  input  logic             i_ex_is_load,
  input  logic [31:0]      i_ex_data,
  input  logic [31:0]      i_mem_data,
  input  logic [31:0]      i_wb_data,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_valid,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_rs1_data,
  output logic [31:0]      o_rs2_data,
  output logic [4:0]       o_rd,
  output logic             o_rd_we,
  output logic             o_is_load,
  output logic [CNT_W-1:0] o_stall_count
);

  logic             vld_p1;
  logic [31:0]      pc_p1;
  logic [31:0]      rs1_data_p1;
  logic [31:0]      rs2_data_p1;
  logic [4:0]       rd_p1;
  logic             rd_we_p1;
  logic             is_load_p1;
  logic [CNT_W-1:0] stall_cnt;

  logic             advance;
  logic             hazard;
  logic             accept;
  logic [31:0]      rs1_res_p0;
  logic [31:0]      rs2_res_p0;

  // A loading EX producer cannot forward yet; that case is covered by the hazard bubble.
  function automatic logic [31:0] resolve(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic [4:0]  ex_rd,  input logic ex_we,  input logic ex_is_load, input logic [31:0] ex_data,
    input logic [4:0]  mem_rd, input logic mem_we, input logic [31:0] mem_data,
    input logic [4:0]  wb_rd,  input logic wb_we,  input logic [31:0] wb_data
  );
    logic [31:0] r;
    if (idx == 5'd0)                                 r = 32'd0;
    else if (ex_we && ex_rd == idx && !ex_is_load)   r = ex_data;
    else if (mem_we && mem_rd == idx)                r = mem_data;
    else if (FORWARD_WB && wb_we && wb_rd == idx)    r = wb_data;
    else                                             r = rf_data;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    advance = !vld_p1 || i_ready;
    hazard  = i_valid && i_ex_we && i_ex_is_load && (i_ex_rd != 5'd0) &&
              ((i_rs1_used && i_rs1 == i_ex_rd) || (i_rs2_used && i_rs2 == i_ex_rd));
    accept  = i_valid && !hazard;
    o_stall = i_valid && !i_flush && (hazard || !advance);
    rs1_res_p0 = resolve(i_rs1, i_rf_rs1_data, i_ex_rd, i_ex_we, i_ex_is_load, i_ex_data,
                         i_mem_rd, i_mem_we, i_mem_data, i_wb_rd, i_wb_we, i_wb_data);
    rs2_res_p0 = resolve(i_rs2, i_rf_rs2_data, i_ex_rd, i_ex_we, i_ex_is_load, i_ex_data,
                         i_mem_rd, i_mem_we, i_mem_data, i_wb_rd, i_wb_we, i_wb_data);
  end

  // p0 -> p1: operands are captured once at entry and held while execute back-pressures.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      rd_p1       <= '0;
      rd_we_p1    <= 1'b0;
      is_load_p1  <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (i_flush) begin
        vld_p1 <= 1'b0;
      end else if (advance) begin
        vld_p1 <= accept;
        if (accept) begin
          pc_p1       <= i_pc;
          rs1_data_p1 <= rs1_res_p0;
          rs2_data_p1 <= rs2_res_p0;
          rd_p1       <= i_rd;
          rd_we_p1    <= i_rd_we;
          is_load_p1  <= i_is_load;
        end
      end
      if (hazard && advance && !i_flush)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign o_valid       = vld_p1;
  assign o_pc          = pc_p1;
  assign o_rs1_data    = rs1_data_p1;
  assign o_rs2_data    = rs2_data_p1;
  assign o_rd          = rd_p1;
  assign o_rd_we       = rd_we_p1;
  assign o_is_load     = is_load_p1;
  assign o_stall_count = stall_cnt;

endmodule
